// File: rtl/sw_act_pkg.sv
// Shared types and constants for the switching activity monitor and its harness.
package sw_act_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int DEF_WIDTH  = 5;
  localparam int DEF_WINDOW = 256;

  // Ceiling log2; callers always pass values >= 2.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/switching_activity_monitor_if.sv
// Sample and result bus between the power-experiment harness and the monitor.
// The res_peak signal exists only when SWACT_PEAK_EN is defined.
interface switching_activity_monitor_if
  import sw_act_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WINDOW = DEF_WINDOW
) ();

  localparam int CNT_W = clog2((WINDOW - 1) * WIDTH + 1);
  localparam int SMP_W = clog2(WINDOW + 1);
  localparam int PK_W  = clog2(WIDTH + 1);

  logic             start;
  logic             smp_valid;
  logic [WIDTH-1:0] smp_data;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_toggles;
  logic [SMP_W-1:0] res_ones;
`ifdef SWACT_PEAK_EN
  logic [PK_W-1:0]  res_peak;
`endif

  modport master (
    output start, smp_valid, smp_data, res_ready,
`ifdef SWACT_PEAK_EN
    input  res_peak,
`endif
    input  busy, res_valid, res_toggles, res_ones
  );

  modport slave (
    input  start, smp_valid, smp_data, res_ready,
`ifdef SWACT_PEAK_EN
    output res_peak,
`endif
    output busy, res_valid, res_toggles, res_ones
  );

endinterface

// File: rtl/sw_act_popcount.sv
// Number of bits that differ between the current and previous sample.
module sw_act_popcount
  import sw_act_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PC_W  = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [PC_W-1:0]  count
);

  logic [WIDTH-1:0] diff;

  // Sum the XOR bits; purely combinational.
  always_comb begin
    diff  = a ^ b;
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + PC_W'(diff[i]);
    end
  end

endmodule

// File: rtl/switching_activity_monitor.sv
// Counts bit toggles and output-high samples over a window of WINDOW samples
// and returns one result per armed window over a valid/ready handshake.
// Define SWACT_PEAK_EN to add res_peak, the largest single-transition toggle count.
module switching_activity_monitor
  import sw_act_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WINDOW = DEF_WINDOW
) (
  input logic clock,
  input logic reset,
  switching_activity_monitor_if.slave bus
);

  localparam int CNT_W = clog2((WINDOW - 1) * WIDTH + 1);
  localparam int SMP_W = clog2(WINDOW + 1);
  localparam int PK_W  = clog2(WIDTH + 1);

  generate
    if (WINDOW < 2) begin : g_window_check
      $error("switching_activity_monitor: WINDOW must be at least 2");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [CNT_W-1:0] toggles;
  logic [SMP_W-1:0] ones;
  logic [SMP_W-1:0] samples;
  logic [PK_W-1:0]  pc;
  logic [CNT_W-1:0] toggles_next;
  logic [SMP_W-1:0] ones_next;
  logic             last_sample;
`ifdef SWACT_PEAK_EN
  logic [PK_W-1:0]  peak;
  logic [PK_W-1:0]  peak_next;
`endif

  sw_act_popcount #(.WIDTH(WIDTH), .PC_W(PK_W)) u_popcount (
    .a     (bus.smp_data),
    .b     (prev),
    .count (pc)
  );

  // Accumulator values after accepting the current sample.
  always_comb begin
    toggles_next = toggles + CNT_W'(pc);
    ones_next    = ones + SMP_W'(bus.smp_data[WIDTH-1]);
    last_sample  = (samples == SMP_W'(WINDOW - 1));
`ifdef SWACT_PEAK_EN
    peak_next    = (pc > peak) ? pc : peak;
`endif
  end

  // Window FSM with registered busy/result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      prev            <= '0;
      toggles         <= '0;
      ones            <= '0;
      samples         <= '0;
      bus.busy        <= 1'b0;
      bus.res_valid   <= 1'b0;
      bus.res_toggles <= '0;
      bus.res_ones    <= '0;
`ifdef SWACT_PEAK_EN
      peak            <= '0;
      bus.res_peak    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= ARM;
            bus.busy <= 1'b1;
`ifdef SWACT_PEAK_EN
            peak     <= '0;
`endif
          end
        end
        ARM: begin
          // First sample only seeds prev; it has no predecessor to toggle against.
          if (bus.smp_valid) begin
            prev    <= bus.smp_data;
            ones    <= SMP_W'(bus.smp_data[WIDTH-1]);
            samples <= SMP_W'(1);
            toggles <= '0;
            state   <= COUNT;
          end
        end
        COUNT: begin
          if (bus.smp_valid) begin
            prev    <= bus.smp_data;
            toggles <= toggles_next;
            ones    <= ones_next;
            samples <= samples + SMP_W'(1);
`ifdef SWACT_PEAK_EN
            peak    <= peak_next;
`endif
            if (last_sample) begin
              state           <= REPORT;
              bus.busy        <= 1'b0;
              bus.res_valid   <= 1'b1;
              bus.res_toggles <= toggles_next;
              bus.res_ones    <= ones_next;
`ifdef SWACT_PEAK_EN
              bus.res_peak    <= peak_next;
`endif
            end
          end
        end
        REPORT: begin
          if (bus.res_ready) begin
            state         <= IDLE;
            bus.res_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/switching_activity_monitor.md
Name: switching_activity_monitor

Overview:
- Downstream consumer of an ABC-generated combinational power sub-circuit: samples the sub-circuit's primary inputs plus output as one vector.
- Over a fixed window of samples, counts bit toggles (switching activity) and how often the output bit is high (signal probability).
- Returns one result per armed window through a valid/ready handshake to the power-experiment harness.

Parameters:
- WIDTH, 5, sampled vector width; bits [WIDTH-2:0] are sub-circuit inputs, bit [WIDTH-1] is the sub-circuit output.
- WINDOW, 256, samples per window; must be >= 2 (elaboration-time assertion).
- CNT_W (localparam), clog2((WINDOW-1)*WIDTH+1), width of the toggle accumulator.
- SMP_W (localparam), clog2(WINDOW+1), width of the sample counter and the ones counter.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  arms a window; honoured only in IDLE.
- smp_valid  in  1  smp_data is valid this cycle; no ready, sampler never stalls.
- smp_data  in  WIDTH  sampled vector.
- busy  out  1  high in ARM and COUNT.
- res_valid  out  1  result available.
- res_ready  in  1  harness accepts result.
- res_toggles  out  CNT_W  total bit toggles across WINDOW-1 transitions.
- res_ones  out  SMP_W  number of samples with smp_data[WIDTH-1]=1.
- res_peak  out  clog2(WIDTH+1)  only with SWACT_PEAK_EN (see below).

Behaviour:
- Reset (sync, any state): state=IDLE; busy=0, res_valid=0, res_toggles=0, res_ones=0, res_peak=0; internal prev/counters cleared.
- IDLE: start=1 -> ARM next cycle. smp_valid is ignored.
- ARM: the first smp_valid captures prev<=smp_data, ones<=smp_data[WIDTH-1], samples<=1, toggles<=0; then -> COUNT. No toggle is counted for the first sample.
- COUNT: on each smp_valid:
  - toggles += popcount(smp_data ^ prev); prev<=smp_data.
  - ones += smp_data[WIDTH-1]; samples++.
  - Cycles without smp_valid hold all state (gaps are allowed).
- Window end: when the sample that makes samples==WINDOW is accepted, the next state is REPORT.
  - res_valid=1 and the res_* outputs are loaded on the following edge; latency is 1 cycle after the last sample.
- Arithmetic: unsigned throughout; accumulators are sized so they never overflow, so no saturation logic exists.
- REPORT: res_* are registered and held stable while res_valid=1. smp_valid and start are ignored.
  - res_valid&res_ready -> IDLE; res_valid=0 on the next cycle. res_* keep their last values until the next load.
  - A start in the same cycle as the handshake is dropped; the harness must re-issue it from IDLE.
- start while busy or in REPORT has no effect.
- Reset mid-ARM/COUNT/REPORT aborts the window; no partial result is produced.

Optional Feature:
- Macro SWACT_PEAK_EN.
- Defined: adds port res_peak and a register holding the maximum single-transition popcount seen in the window. It resets to 0 at ARM and is reported and held like the other res_* outputs.
- Undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- Package sw_act_pkg:
  - state enum {IDLE, ARM, COUNT, REPORT} (2-bit).
  - clog2 helper function.
  - default WIDTH/WINDOW constants shared with the harness.
- Sub-module sw_act_popcount: purely combinational, parameterised by WIDTH, returns the popcount of smp_data^prev. Used for the accumulator and the peak comparison.

Test Plan (WIDTH=5, WINDOW=4 unless stated):
- Constant 5'h00 x4 -> res_toggles=0, res_ones=0, res_valid rises 1 cycle after the 4th sample.
- Alternating 5'h1F,5'h00,5'h1F,5'h00 -> res_toggles=15, res_ones=2.
- Samples 5'h00,5'h01,5'h1F,5'h1E -> res_toggles=6, res_ones=2; with SWACT_PEAK_EN, res_peak=4.
- Same stimulus with 0-3 idle cycles between smp_valid pulses -> identical results; busy=1 throughout ARM/COUNT.
- res_ready held low 10 cycles in REPORT, extra smp_valid and start pulses applied -> res_valid stays 1, outputs unchanged. Raise res_ready -> IDLE; a start in the handshake cycle is ignored.
- reset after 2 samples in COUNT -> next cycle busy=0, res_valid=0. A fresh start plus the alternating pattern -> res_toggles=15.
